// File: rtl/esp32_btn_spi_slave_pkg.sv
// Shared types and constants for the ESP32 button SPI slave and its debouncer.
package esp32_btn_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_state_t;

  // Byte indices within a frame
  localparam int C_FRAME_BTN_LEVEL = 0;
  localparam int C_FRAME_BTN_EVENT = 1;

  localparam int C_SYNC_STAGES = 2;

  function automatic logic [1:0] sat_inc(input logic [1:0] value, input logic [1:0] limit);
    return (value >= limit) ? limit : value + 2'd1;
  endfunction

endpackage

// File: rtl/esp32_btn_spi_slave_if.sv
// SPI pins shared with the OLED bus; the ESP32 is master, this block the slave.
interface esp32_btn_spi_slave_if;

  logic spi_csn;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_csn,
    output spi_clk,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_csn,
    input  spi_clk,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );

endinterface

// File: rtl/esp32_btn_spi_slave_debounce.sv
// Button synchroniser, tick prescaler and two-sample history debouncer.
// A level is accepted only after two consecutive ticks agree on it.
module btn_debounce
  import esp32_btn_pkg::*;
#(
  parameter int                    C_btn_bits      = 7,
  parameter logic [C_btn_bits-1:0] C_btn_invert    = 7'b0000001,
  parameter int                    C_debounce_bits = 16
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic [C_btn_bits-1:0] btn,
  output logic [C_btn_bits-1:0] btn_debounced
);

  logic [C_SYNC_STAGES-1:0][C_btn_bits-1:0] btn_sync;
  logic [C_debounce_bits-1:0]               prescale;
  logic [C_btn_bits-1:0]                    hist_new;
  logic [C_btn_bits-1:0]                    hist_old;
  logic [C_btn_bits-1:0]                    agree;
  logic                                     tick;

  assign tick  = &prescale;
  assign agree = ~(hist_new ^ hist_old);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      btn_sync      <= {C_SYNC_STAGES{C_btn_invert}};
      prescale      <= '0;
      hist_new      <= '0;
      hist_old      <= '0;
      btn_debounced <= '0;
    end else begin
      btn_sync <= {btn_sync[C_SYNC_STAGES-2:0], btn};
      prescale <= prescale + C_debounce_bits'(1);
      if (tick) begin
        hist_new <= btn_sync[C_SYNC_STAGES-1] ^ C_btn_invert;
        hist_old <= hist_new;
      end
      btn_debounced <= (hist_new & agree) | (btn_debounced & ~agree);
    end
  end

endmodule

// File: rtl/esp32_btn_spi_slave.sv
// Mode-0 SPI slave in the clk_25mhz domain: serves debounced button levels and
// sticky press events to the ESP32 and captures the first MOSI byte as a command.
module esp32_btn_spi_slave
  import esp32_btn_pkg::*;
#(
  parameter int                    C_btn_bits      = 7,
  parameter logic [C_btn_bits-1:0] C_btn_invert    = 7'b0000001,
  parameter int                    C_debounce_bits = 16
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic [C_btn_bits-1:0] btn,
  esp32_btn_spi_slave_if.slave  spi,
  output logic [C_btn_bits-1:0] btn_debounced,
  output logic [C_btn_bits-1:0] btn_event,
  output logic [7:0]            cmd_byte,
  output logic                  cmd_valid
);

  localparam logic [1:0] BYTE_LEVEL = 2'(C_FRAME_BTN_LEVEL);
  localparam logic [1:0] BYTE_EVENT = 2'(C_FRAME_BTN_EVENT);
  localparam logic [1:0] BYTE_LIMIT = 2'd2;

  spi_state_t            state;
  logic [C_SYNC_STAGES:0] csn_sh;
  logic [C_SYNC_STAGES:0] sclk_sh;
  logic [C_SYNC_STAGES-1:0] mosi_sh;
  logic                  csn_rise, csn_fall, sclk_rise, sclk_fall, mosi_s;
  logic [7:0]            tx;
  logic [6:0]            rx;
  logic [2:0]            bit_cnt;
  logic [1:0]            byte_cnt;
  logic                  load_next;
  logic                  miso_oe;
  logic [C_btn_bits-1:0] snapshot;
  logic [C_btn_bits-1:0] clear_mask;
  logic [C_btn_bits-1:0] deb_prev;
  logic                  byte_done;

  btn_debounce #(
    .C_btn_bits     (C_btn_bits),
    .C_btn_invert   (C_btn_invert),
    .C_debounce_bits(C_debounce_bits)
  ) u_debounce (
    .clk_25mhz    (clk_25mhz),
    .reset        (reset),
    .btn          (btn),
    .btn_debounced(btn_debounced)
  );

  // The CSn chain resets low so a CSn held low through reset is not seen as a
  // fresh falling edge; the interrupted frame is dropped until CSn toggles.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      csn_sh  <= '0;
      sclk_sh <= '0;
      mosi_sh <= '0;
    end else begin
      csn_sh  <= {csn_sh[C_SYNC_STAGES-1:0], spi.spi_csn};
      sclk_sh <= {sclk_sh[C_SYNC_STAGES-1:0], spi.spi_clk};
      mosi_sh <= {mosi_sh[C_SYNC_STAGES-2:0], spi.spi_mosi};
    end
  end

  assign csn_rise  =  csn_sh[C_SYNC_STAGES-1]  & ~csn_sh[C_SYNC_STAGES];
  assign csn_fall  = ~csn_sh[C_SYNC_STAGES-1]  &  csn_sh[C_SYNC_STAGES];
  assign sclk_rise =  sclk_sh[C_SYNC_STAGES-1] & ~sclk_sh[C_SYNC_STAGES];
  assign sclk_fall = ~sclk_sh[C_SYNC_STAGES-1] &  sclk_sh[C_SYNC_STAGES];
  assign mosi_s    =  mosi_sh[C_SYNC_STAGES-1];

  assign byte_done = (state == SHIFT) && !csn_rise && sclk_rise && (bit_cnt == 3'd7);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it holding a value (no inferred latch).
  always_comb begin
    clear_mask = '0;
    if (byte_done && byte_cnt == BYTE_EVENT) begin
      clear_mask = snapshot;
    end
  end

  // A new press in the same cycle as a clear survives.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      deb_prev  <= '0;
      btn_event <= '0;
    end else begin
      deb_prev  <= btn_debounced;
      btn_event <= (btn_event & ~clear_mask) | (btn_debounced & ~deb_prev);
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      load_next <= 1'b0;
      snapshot  <= '0;
      miso_oe   <= 1'b0;
      cmd_byte  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (csn_fall) begin
            state     <= SHIFT;
            miso_oe   <= 1'b1;
            tx        <= 8'(btn_debounced);
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            load_next <= 1'b0;
          end
        end
        SHIFT: begin
          if (csn_rise) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
          end else if (sclk_rise) begin
            rx      <= {rx[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              load_next <= 1'b1;
              byte_cnt  <= sat_inc(byte_cnt, BYTE_LIMIT);
              if (byte_cnt == BYTE_LEVEL) begin
                cmd_byte  <= {rx, mosi_s};
                cmd_valid <= 1'b1;
              end
            end
          end else if (sclk_fall) begin
            if (load_next) begin
              load_next <= 1'b0;
              if (byte_cnt == BYTE_EVENT) begin
                tx       <= 8'(btn_event);
                snapshot <= btn_event;
              end else begin
                tx <= 8'h00;
              end
            end else begin
              tx <= {tx[6:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

  assign spi.spi_miso    = tx[7];
  assign spi.spi_miso_oe = miso_oe;

endmodule

// File: tb/tb_esp32_btn_spi_slave.sv
// Directed-plus-random bench for esp32_btn_spi_slave against a frame-level
// model of button levels, sticky events and command capture.
module tb_esp32_btn_spi_slave;

  localparam int         DB     = 4;
  localparam int         TICK   = 1 << DB;
  localparam int         SETTLE = 3 * TICK + 8;
  localparam logic [6:0] INV    = 7'b0000001;

  logic       clk_25mhz = 1'b0;
  logic       reset;
  logic [6:0] btn;
  logic [6:0] btn_debounced;
  logic [6:0] btn_event;
  logic [7:0] cmd_byte;
  logic       cmd_valid;

  esp32_btn_spi_slave_if spi ();

  esp32_btn_spi_slave #(
    .C_btn_bits     (7),
    .C_btn_invert   (INV),
    .C_debounce_bits(DB)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .reset        (reset),
    .btn          (btn),
    .spi          (spi),
    .btn_debounced(btn_debounced),
    .btn_event    (btn_event),
    .cmd_byte     (cmd_byte),
    .cmd_valid    (cmd_valid)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;

  always @(negedge clk_25mhz) if (cmd_valid === 1'b1) valid_cnt++;

  // Reference model state: what the ESP32 should observe
  logic [6:0] m_level  = '0;
  logic [6:0] m_events = '0;
  logic [7:0] m_cmd    = '0;
  logic [7:0] rx_b [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_buttons(input logic [6:0] mask, input string tag);
    btn = mask ^ INV;
    wait_cycles(SETTLE);
    m_events = m_events | (mask & ~m_level);
    m_level  = mask;
    check({tag, "/level"}, 32'(btn_debounced), 32'(m_level));
    check({tag, "/event"}, 32'(btn_event), 32'(m_events));
  endtask

  // One SPI master transaction at SCLK = clk/8; optionally cut short by a CSn
  // rise or by a reset pulse after a given number of bits.
  task automatic spi_frame(input string tag, input int nbytes, input logic [7:0] b0,
                           input int stop_bits, input int rst_bits, input logic [6:0] press1);
    logic [7:0] mo;
    logic [6:0] exp0, snap, new_press;
    int         bits = 0;
    int         full;
    int         wt;
    int         v0   = valid_cnt;
    bit         cut  = 1'b0;
    bit         did_reset = 1'b0;
    exp0 = m_level;
    snap = m_events;
    new_press = press1 & ~m_level;
    for (int i = 0; i < 3; i++) rx_b[i] = 8'hxx;

    spi.spi_csn = 1'b0;
    wait_cycles(8);
    check({tag, "/oe_on"}, 32'(spi.spi_miso_oe), 32'd1);
    for (int by = 0; by < nbytes && !cut; by++) begin
      mo = (by == 0) ? b0 : 8'($urandom);
      for (int bi = 7; bi >= 0 && !cut; bi--) begin
        spi.spi_mosi = mo[bi];
        wait_cycles(4);
        rx_b[by][bi] = spi.spi_miso;
        spi.spi_clk = 1'b1;
        wait_cycles(4);
        spi.spi_clk = 1'b0;
        bits++;
        if (by == 1 && bi == 7 && press1 != 7'h00) btn = (m_level | press1) ^ INV;
        if (bits == stop_bits || bits == rst_bits) cut = 1'b1;
      end
    end
    wait_cycles(4);

    if (rst_bits != 0 && bits == rst_bits) begin
      reset = 1'b1;
      wait_cycles(2);
      check({tag, "/rst_deb"},   32'(btn_debounced),   32'd0);
      check({tag, "/rst_event"}, 32'(btn_event),       32'd0);
      check({tag, "/rst_cmd"},   32'(cmd_byte),        32'd0);
      check({tag, "/rst_valid"}, 32'(cmd_valid),       32'd0);
      check({tag, "/rst_miso"},  32'(spi.spi_miso),    32'd0);
      check({tag, "/rst_oe"},    32'(spi.spi_miso_oe), 32'd0);
      reset = 1'b0;
      did_reset = 1'b1;
    end

    spi.spi_csn = 1'b1;
    wt = 0;
    while (spi.spi_miso_oe !== 1'b0 && wt < 6) begin
      wait_cycles(1);
      wt++;
    end
    check({tag, "/oe_off"}, 32'(spi.spi_miso_oe), 32'd0);
    wait_cycles(SETTLE);

    full = bits / 8;
    if (full >= 1) begin
      check({tag, "/miso0"}, 32'(rx_b[0]), 32'(exp0));
      m_cmd = b0;
    end
    if (full >= 2) begin
      check({tag, "/miso1"}, 32'(rx_b[1]), 32'(snap));
      m_events = m_events & ~snap;
    end
    if (full >= 3) check({tag, "/miso2"}, 32'(rx_b[2]), 32'd0);
    check({tag, "/valid_cnt"}, 32'(valid_cnt - v0), (full >= 1) ? 32'd1 : 32'd0);

    m_events = m_events | new_press;
    m_level  = m_level | press1;
    if (did_reset) begin
      m_cmd    = 8'h00;
      m_events = m_level;
    end
    check({tag, "/cmd"},   32'(cmd_byte),      32'(m_cmd));
    check({tag, "/event"}, 32'(btn_event),     32'(m_events));
    check({tag, "/level"}, 32'(btn_debounced), 32'(m_level));
  endtask

  initial begin
    int         wt;
    logic [6:0] mask;
    reset        = 1'b1;
    btn          = INV;
    spi.spi_csn  = 1'b1;
    spi.spi_clk  = 1'b0;
    spi.spi_mosi = 1'b0;

    // Reset state
    wait_cycles(4);
    check("reset/deb",   32'(btn_debounced),   32'd0);
    check("reset/event", 32'(btn_event),       32'd0);
    check("reset/cmd",   32'(cmd_byte),        32'd0);
    check("reset/valid", 32'(cmd_valid),       32'd0);
    check("reset/miso",  32'(spi.spi_miso),    32'd0);
    check("reset/oe",    32'(spi.spi_miso_oe), 32'd0);
    reset = 1'b0;
    wait_cycles(SETTLE);
    check("idle/deb",   32'(btn_debounced), 32'd0);
    check("idle/event", 32'(btn_event),     32'd0);

    // Sub-tick glitches on btn[1] must be filtered out
    for (int g = 0; g < 3; g++) begin
      btn = 7'b0000011;
      wait_cycles(6);
      btn = INV;
      wait_cycles(26);
    end
    wait_cycles(SETTLE);
    check("glitch/deb",   32'(btn_debounced), 32'd0);
    check("glitch/event", 32'(btn_event),     32'd0);

    // Held press appears within two ticks plus synchroniser delay
    btn = 7'b0000011;
    wt  = 0;
    while (btn_debounced[1] !== 1'b1 && wt < 2 * TICK + 6) begin
      wait_cycles(1);
      wt++;
    end
    check("press/deb", 32'(btn_debounced), 32'h02);
    wait_cycles(2);
    check("press/event", 32'(btn_event), 32'h02);
    m_level  = 7'h02;
    m_events = 7'h02;

    spi_frame("frame_a5", 2, 8'hA5, 0, 0, 7'h00);

    set_buttons(7'h00, "release1");
    set_buttons(7'h02, "repress1");
    spi_frame("press_in_b1", 2, 8'($urandom), 0, 0, 7'h04);

    spi_frame("abort5", 2, 8'($urandom), 5, 0, 7'h00);
    spi_frame("after_abort", 2, 8'($urandom), 0, 0, 7'h00);

    spi_frame("three_byte", 3, 8'($urandom), 0, 0, 7'h00);

    for (int it = 0; it < 8; it++) begin
      mask = 7'($urandom);
      set_buttons(mask, "rand_btn");
      spi_frame("rand_frame", int'($urandom_range(1, 3)), 8'($urandom), 0, 0, 7'h00);
    end

    set_buttons(7'h06 | 7'($urandom), "pre_reset");
    spi_frame("reset_mid_b1", 2, 8'($urandom), 0, 11, 7'h00);
    spi_frame("post_reset", 2, 8'($urandom), 0, 0, 7'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
